// File: rtl/mem_burst_reader.sv
// Burst reader for a parity-protected 9-bit memory; optional MEM_BURST_HALT_ON_PERR_EN ends a burst on the first bad word.
// Latency: first mem_read 1 cycle after start; 3 cycles per word (issue, capture, present) when out_ready is high.
// Backpressure: a presented word holds steady until out_ready; the next read is not issued until then.
module mem_burst_reader #(
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [15:0]      start_addr,
   input  logic [15:0]      length,
   output logic             mem_read,
   output logic [15:0]      mem_addr,
   input  logic [8:0]       mem_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic [15:0]      out_addr,
   output logic             out_perr,
   output logic             busy,
   output logic             done,
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      CAPTURE = 3'd2,
      PRESENT = 3'd3,
      FINISH  = 3'd4
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] addr;
   logic [15:0] remaining;
   logic        halt_on_err;

   // A bad word ends the burst early only when the halt option is built in.
`ifdef MEM_BURST_HALT_ON_PERR_EN
   assign halt_on_err = out_perr;
`else
   assign halt_on_err = 1'b0;
`endif

   // State register; reset aborts any burst in progress without a done pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode plus the strobes that are pure functions of state.
   always_comb begin
      state_nxt = state;
      mem_read  = 1'b0;
      mem_addr  = 16'h0000;
      out_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (length == 16'd0) ? FINISH : ISSUE;
            end
         end
         ISSUE: begin
            mem_read  = 1'b1;
            mem_addr  = addr;
            busy      = 1'b1;
            state_nxt = CAPTURE;
         end
         CAPTURE: begin
            busy      = 1'b1;
            state_nxt = PRESENT;
         end
         PRESENT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = ((remaining == 16'd1) || halt_on_err) ? FINISH : ISSUE;
            end
         end
         FINISH: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Burst bookkeeping, captured word and the saturating error tally.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr      <= 16'h0000;
         remaining <= 16'h0000;
         out_data  <= 8'h00;
         out_addr  <= 16'h0000;
         out_perr  <= 1'b0;
         err_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  addr      <= start_addr;
                  remaining <= length;
                  err_count <= '0;
               end
            end
            CAPTURE: begin
               // Memory output is registered, so the word for addr is on mem_data now.
               out_data <= mem_data[7:0];
               out_addr <= addr;
               out_perr <= ~(^mem_data);
            end
            PRESENT: begin
               if (out_ready) begin
                  if (out_perr && (err_count != '1)) begin
                     err_count <= err_count + ERR_W'(1);
                  end
                  addr      <= addr + 16'd1;
                  remaining <= remaining - 16'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_burst_reader.sv
// Self-checking bench for mem_burst_reader with a registered 9-bit memory model.
// Expected streams come from a word-list model built from the memory contents.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_mem_burst_reader;

   localparam int ERR_W   = 8;
   localparam int ERR_MAX = (1 << ERR_W) - 1;
   localparam int LIMIT   = 20000;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [15:0]      start_addr;
   logic [15:0]      length;
   logic             mem_read;
   logic [15:0]      mem_addr;
   logic [8:0]       mem_data;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_data;
   logic [15:0]      out_addr;
   logic             out_perr;
   logic             busy;
   logic             done;
   logic [ERR_W-1:0] err_count;

   mem_burst_reader #(.ERR_W(ERR_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .length(length),
      .mem_read(mem_read), .mem_addr(mem_addr), .mem_data(mem_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
      .out_perr(out_perr), .busy(busy), .done(done), .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory with registered data_out: read at one edge, data visible until the next read.
   logic [8:0] mem [0:65535];
   initial mem_data = 9'h000;
   always @(posedge clk) begin
      if (mem_read) mem_data <= mem[mem_addr];
   end

   int n_checks = 0;
   int n_pass   = 0;

   // Observations of one burst
   logic [15:0] obs_addr [$];
   logic [7:0]  obs_data [$];
   logic        obs_perr [$];
   logic [15:0] rd_addr  [$];
   int          busy_cycles, done_cycle, first_rd, stable_viol, done_pulses;
   bit          timed_out;
   logic [ERR_W-1:0] final_err;

   // Model expectations
   logic [15:0] exp_addr [$];
   logic [7:0]  exp_data [$];
   logic        exp_perr [$];
   logic [ERR_W-1:0] exp_err;

   task automatic wr_good(input logic [15:0] a, input logic [7:0] d);
      mem[a] = {~(^d), d};
   endtask

   task automatic wr_bad(input logic [15:0] a, input logic [7:0] d);
      mem[a] = {^d, d};
   endtask

   // A word is good when its nine bits contain an odd number of ones.
   task automatic model_burst(input logic [15:0] sa, input logic [15:0] len);
      logic [15:0] a;
      int errs;
      logic bad;
      a = sa;
      errs = 0;
      exp_addr.delete(); exp_data.delete(); exp_perr.delete();
      for (int i = 0; i < int'(len); i++) begin
         bad = ($countones(mem[a]) % 2) == 0;
         exp_addr.push_back(a);
         exp_data.push_back(mem[a][7:0]);
         exp_perr.push_back(bad);
         if (bad && errs < ERR_MAX) errs++;
         a = a + 16'd1;
`ifdef MEM_BURST_HALT_ON_PERR_EN
         if (bad) break;
`endif
      end
      exp_err = ERR_W'(errs);
   endtask

   // Drives one burst and records what the DUT does; mode 0 ready high, 1 stall word 2 for 5 cycles, 2 random ready.
   task automatic run_burst(input logic [15:0] sa, input logic [15:0] len, input int mode,
                            input int inj_cyc, input logic [15:0] inj_addr);
      int cyc, hold, widx;
      logic pend, pp;
      logic [7:0] pd;
      logic [15:0] pa;
      obs_addr.delete(); obs_data.delete(); obs_perr.delete(); rd_addr.delete();
      busy_cycles = 0; done_cycle = -1; first_rd = -1; stable_viol = 0; done_pulses = 0;
      timed_out = 0; hold = 0; widx = 0; pend = 0; pp = 0; pd = 8'h00; pa = 16'h0000; cyc = 0;
      @(negedge clk);
      start_addr = sa; length = len; start = 1'b1; out_ready = 1'b1;
      while (1) begin
         @(negedge clk);
         cyc++;
         start = (cyc == inj_cyc);
         start_addr = (cyc == inj_cyc) ? inj_addr : sa;
         case (mode)
            1: begin
               if (out_valid && widx == 2 && hold < 5) begin
                  out_ready = 1'b0;
                  hold++;
               end else begin
                  out_ready = 1'b1;
               end
            end
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
         endcase
         if (mem_read) begin
            rd_addr.push_back(mem_addr);
            if (first_rd < 0) first_rd = cyc;
         end
         if (busy) busy_cycles++;
         if (done) begin
            done_pulses++;
            if (done_cycle < 0) done_cycle = cyc;
         end
         if (out_valid) begin
            if (pend && (out_data !== pd || out_addr !== pa || out_perr !== pp)) stable_viol++;
            if (out_ready) begin
               obs_addr.push_back(out_addr);
               obs_data.push_back(out_data);
               obs_perr.push_back(out_perr);
               widx++;
               pend = 0;
            end else begin
               pend = 1; pd = out_data; pa = out_addr; pp = out_perr;
            end
         end
         if (done_cycle >= 0 && cyc >= done_cycle + 2) break;
         if (cyc >= LIMIT) begin
            timed_out = 1;
            break;
         end
      end
      final_err = err_count;
      start = 1'b0;
      out_ready = 1'b1;
   endtask

   // Index of first word where DUT stream or read addresses differ from the model, else -1.
   function automatic int stream_diff();
      int n;
      n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
      for (int i = 0; i < n; i++) begin
         if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_perr[i] !== exp_perr[i])
            return i;
         if (i < rd_addr.size() && rd_addr[i] !== exp_addr[i]) return i;
      end
      return -1;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; start_addr = 16'h0000; length = 16'h0000; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({mem_read, mem_addr, out_valid, out_data, out_addr, out_perr, busy, done, err_count} !== '0)
         $display("FAIL reset_outputs: got rd=%b ma=%h v=%b d=%h a=%h p=%b busy=%b done=%b err=%0d want all 0",
                  mem_read, mem_addr, out_valid, out_data, out_addr, out_perr, busy, done, err_count);
      else n_pass++;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({mem_read, busy, done, out_valid} !== 4'b0000)
         $display("FAIL reset_idle: got rd=%b busy=%b done=%b v=%b want 0", mem_read, busy, done, out_valid);
      else n_pass++;
   endtask

   task automatic test_basic();
      int d;
      for (int i = 0; i < 4; i++) wr_good(16'h0010 + 16'(i), 8'(i));
      model_burst(16'h0010, 16'd4);
      run_burst(16'h0010, 16'd4, 0, 0, 16'h0000);
      d = stream_diff();
      n_checks++;
      if (timed_out || obs_addr.size() != 4) $display("FAIL basic_count: got %0d words timeout=%0d want 4", obs_addr.size(), timed_out);
      else n_pass++;
      n_checks++;
      if (d != -1) $display("FAIL basic_stream: word %0d got a=%h d=%h p=%b want a=%h d=%h p=%b",
                            d, obs_addr[d], obs_data[d], obs_perr[d], exp_addr[d], exp_data[d], exp_perr[d]);
      else n_pass++;
      n_checks++;
      if (rd_addr.size() != 4) $display("FAIL basic_reads: got %0d reads want 4", rd_addr.size());
      else n_pass++;
      n_checks++;
      if (first_rd != 1) $display("FAIL basic_first_read: got cycle %0d want 1", first_rd);
      else n_pass++;
      n_checks++;
      if (busy_cycles != 12) $display("FAIL basic_busy: got %0d cycles want 12", busy_cycles);
      else n_pass++;
      n_checks++;
      if (done_cycle != 13 || done_pulses != 1) $display("FAIL basic_done: got cycle %0d pulses %0d want 13 and 1", done_cycle, done_pulses);
      else n_pass++;
      n_checks++;
      if (final_err !== 0) $display("FAIL basic_err: got %0d want 0", final_err);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int d;
      model_burst(16'h0010, 16'd4);
      run_burst(16'h0010, 16'd4, 1, 0, 16'h0000);
      d = stream_diff();
      n_checks++;
      if (timed_out || obs_addr.size() != 4 || d != -1) $display("FAIL bp_stream: got %0d words first diff %0d want 4 and -1", obs_addr.size(), d);
      else n_pass++;
      n_checks++;
      if (rd_addr.size() != 4) $display("FAIL bp_reads: got %0d reads want 4", rd_addr.size());
      else n_pass++;
      n_checks++;
      if (stable_viol != 0) $display("FAIL bp_stable: got %0d changes while stalled want 0", stable_viol);
      else n_pass++;
      n_checks++;
      if (busy_cycles != 17) $display("FAIL bp_busy: got %0d cycles want 17", busy_cycles);
      else n_pass++;
   endtask

   task automatic test_parity();
      int d;
      mem[16'h0020] = 9'h007;
      mem[16'h0021] = 9'h107;
      wr_good(16'h0022, 8'h22);
      wr_good(16'h0023, 8'h23);
      model_burst(16'h0020, 16'd2);
      run_burst(16'h0020, 16'd2, 0, 0, 16'h0000);
      n_checks++;
      if (timed_out || obs_perr.size() != 2 || obs_perr[0] !== 1'b0 || obs_perr[1] !== 1'b1)
         $display("FAIL parity_flags: got %0d words want perr 0 then 1", obs_perr.size());
      else n_pass++;
      n_checks++;
      if (final_err !== exp_err) $display("FAIL parity_err: got %0d want %0d", final_err, exp_err);
      else n_pass++;
      model_burst(16'h0021, 16'd3);
      run_burst(16'h0021, 16'd3, 0, 0, 16'h0000);
      d = stream_diff();
      n_checks++;
      if (timed_out || obs_addr.size() != exp_addr.size() || rd_addr.size() != exp_addr.size() || d != -1)
         $display("FAIL parity_run: got %0d words %0d reads diff %0d want %0d words", obs_addr.size(), rd_addr.size(), d, exp_addr.size());
      else n_pass++;
   endtask

   task automatic test_wrap_zero();
      wr_good(16'hFFFF, 8'hEE);
      wr_good(16'h0000, 8'h11);
      model_burst(16'hFFFF, 16'd2);
      run_burst(16'hFFFF, 16'd2, 0, 0, 16'h0000);
      n_checks++;
      if (timed_out || rd_addr.size() != 2 || rd_addr[0] !== 16'hFFFF || rd_addr[1] !== 16'h0000)
         $display("FAIL wrap_addr: got %0d reads want FFFF then 0000", rd_addr.size());
      else n_pass++;
      n_checks++;
      if (stream_diff() != -1 || obs_addr.size() != 2) $display("FAIL wrap_stream: got %0d words diff %0d want 2 and -1", obs_addr.size(), stream_diff());
      else n_pass++;
      run_burst(16'h0020, 16'd0, 0, 0, 16'h0000);
      n_checks++;
      if (timed_out || done_cycle != 1 || done_pulses != 1) $display("FAIL zero_done: got cycle %0d pulses %0d want 1 and 1", done_cycle, done_pulses);
      else n_pass++;
      n_checks++;
      if (rd_addr.size() != 0 || busy_cycles != 0 || obs_addr.size() != 0)
         $display("FAIL zero_idle: got %0d reads %0d busy %0d words want 0", rd_addr.size(), busy_cycles, obs_addr.size());
      else n_pass++;
      n_checks++;
      if (final_err !== 0) $display("FAIL zero_err_clear: got %0d want 0", final_err);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int nacc, cyc, dn, bz;
      bit hit;
      nacc = 0; cyc = 0; hit = 0; dn = 0; bz = 0;
      wr_good(16'h0030, 8'hA5);
      wr_good(16'h0031, 8'h5A);
      wr_good(16'h0032, 8'h3C);
      wr_good(16'h0033, 8'hC3);
      @(negedge clk);
      start_addr = 16'h0030; length = 16'd4; start = 1'b1; out_ready = 1'b1;
      while (!hit && cyc < 100) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (out_valid) begin
            if (nacc == 0) nacc = 1;
            else begin
               out_ready = 1'b0;
               hit = 1;
            end
         end
      end
      n_checks++;
      if (!hit || out_data !== 8'h5A) $display("FAIL rstmid_reach: got hit=%0d d=%h want word 1 data 5a", hit, out_data);
      else n_pass++;
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({mem_read, mem_addr, out_valid, out_data, out_addr, out_perr, busy, done, err_count} !== '0)
         $display("FAIL rstmid_outputs: got rd=%b v=%b d=%h a=%h busy=%b done=%b err=%0d want all 0",
                  mem_read, out_valid, out_data, out_addr, busy, done, err_count);
      else n_pass++;
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (done) dn++;
         if (busy) bz++;
      end
      n_checks++;
      if (dn != 0 || bz != 0) $display("FAIL rstmid_no_done: got %0d done %0d busy cycles want 0", dn, bz);
      else n_pass++;
      model_burst(16'h0010, 16'd4);
      run_burst(16'h0010, 16'd4, 0, 0, 16'h0000);
      n_checks++;
      if (timed_out || obs_addr.size() != 4 || stream_diff() != -1 || done_cycle != 13)
         $display("FAIL rstmid_clean: got %0d words diff %0d done %0d want 4, -1, 13", obs_addr.size(), stream_diff(), done_cycle);
      else n_pass++;
   endtask

   task automatic test_start_busy();
      wr_good(16'h0040, 8'h99);
      model_burst(16'h0010, 16'd4);
      run_burst(16'h0010, 16'd4, 0, 5, 16'h0040);
      n_checks++;
      if (timed_out || obs_addr.size() != 4 || rd_addr.size() != 4 || stream_diff() != -1)
         $display("FAIL busy_start_ignored: got %0d words %0d reads diff %0d want 4 4 -1", obs_addr.size(), rd_addr.size(), stream_diff());
      else n_pass++;
      n_checks++;
      if (busy_cycles != 12 || done_pulses != 1) $display("FAIL busy_start_len: got %0d busy %0d done want 12 and 1", busy_cycles, done_pulses);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [15:0] sa, len;
      for (int b = 0; b < 6; b++) begin
         sa  = 16'($urandom_range(16'h0100, 16'hF000));
         len = 16'($urandom_range(1, 24));
         for (int i = 0; i < int'(len); i++) mem[sa + 16'(i)] = 9'($urandom_range(0, 511));
         model_burst(sa, len);
         run_burst(sa, len, 2, 0, 16'h0000);
         n_checks++;
         if (timed_out || obs_addr.size() != exp_addr.size() || rd_addr.size() != exp_addr.size())
            $display("FAIL rand_count: burst %0d got %0d words %0d reads want %0d", b, obs_addr.size(), rd_addr.size(), exp_addr.size());
         else n_pass++;
         n_checks++;
         if (stream_diff() != -1) $display("FAIL rand_stream: burst %0d first diff at word %0d want none", b, stream_diff());
         else n_pass++;
         n_checks++;
         if (final_err !== exp_err || stable_viol != 0)
            $display("FAIL rand_err: burst %0d got err %0d stall changes %0d want %0d and 0", b, final_err, stable_viol, exp_err);
         else n_pass++;
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 260; i++) wr_bad(16'h2000 + 16'(i), 8'(i));
      model_burst(16'h2000, 16'd260);
      run_burst(16'h2000, 16'd260, 0, 0, 16'h0000);
      n_checks++;
      if (timed_out || obs_addr.size() != exp_addr.size())
         $display("FAIL sat_count: got %0d words want %0d", obs_addr.size(), exp_addr.size());
      else n_pass++;
      n_checks++;
      if (final_err !== exp_err) $display("FAIL sat_err: got %0d want %0d", final_err, exp_err);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_parity();
      test_wrap_zero();
      test_reset_mid();
      test_start_busy();
      test_random();
      test_saturate();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_burst_reader.md
Name: mem_burst_reader

Overview:
- Downstream consumer of the parity-protected 9-bit word memory (`{parity, data[7:0]}`, odd parity).
- Issues single-word reads over a programmed address range and checks parity on each word.
- Presents each data byte on a valid/ready stream with a per-word error flag.
- Keeps a saturating parity-error count for the burst.

Parameters:
- ERR_W, 8, width of the saturating parity-error counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle burst request; sampled only in IDLE.
- start_addr  input  16  first memory address of the burst.
- length  input  16  number of words to read; 0 is legal.
- mem_read  output  1  read strobe to memory.
- mem_addr  output  16  address to memory.
- mem_data  input  9  memory data_out: bit 8 parity, bits 7:0 data.
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- out_data  output  8  data byte.
- out_addr  output  16  address the byte came from.
- out_perr  output  1  parity error on this word.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at burst end.
- err_count  output  ERR_W  parity errors in the current or last burst; saturates at all-ones.

Behaviour:
- Reset (rst_n low at posedge) forces state IDLE and clears every output to 0: mem_read, mem_addr, out_valid, out_data, out_addr, out_perr, busy, done, err_count. Internal address and remaining count also clear to 0.
- Reset mid-burst aborts at that edge: no done pulse, and any pending word is dropped.
- FSM states: IDLE, ISSUE, CAPTURE, PRESENT, FINISH.
- IDLE:
  - On start=1: latch start_addr and length, clear err_count.
  - If length==0, go to FINISH.
  - Otherwise go to ISSUE.
  - start in any other state is ignored.
- ISSUE: mem_read=1 and mem_addr=current address for exactly one cycle, then go to CAPTURE. mem_write is never driven; this block is read-only.
- CAPTURE: memory's data_out is valid in this cycle (registered one edge after the read).
  - Register mem_data[7:0] into out_data and the current address into out_addr.
  - out_perr = ~(^mem_data[8:0]); a word is good when its 9 bits hold an odd number of ones.
  - Go to PRESENT with out_valid=1.
- PRESENT:
  - Hold out_valid, out_data, out_addr and out_perr stable until out_ready=1.
  - On accept: if out_perr, increment err_count (saturating); increment the address (16'hFFFF wraps to 16'h0000); decrement remaining.
  - If remaining becomes 0, go to FINISH; else go to ISSUE.
  - out_valid drops on the accept edge.
- FINISH: done=1 for one cycle, busy=0, return to IDLE. err_count holds until the next accepted start.
- Latency: with out_ready tied high, 3 cycles per word (ISSUE, CAPTURE, PRESENT), and the first mem_read is asserted 1 cycle after start.
- busy=1 in ISSUE, CAPTURE and PRESENT; busy=0 in IDLE and FINISH.
- Only one read is outstanding at a time; there is no pipelining across words.
- Unwritten addresses are outside the contract; benches read only written locations.

Optional Feature:
- Macro: MEM_BURST_HALT_ON_PERR_EN.
- Defined: when a word with out_perr=1 is accepted, the burst terminates immediately and goes to FINISH. No further reads are issued, so err_count is at most 1.
- Undefined: errors are flagged and counted, and the burst always runs all length words.

Test Plan:
- Write 0x00..0x03 with good parity to addrs 0x0010..0x0013; start_addr=0x0010, length=4, out_ready=1 → bytes 0x00,0x01,0x02,0x03 appear with out_addr 0x0010..0x0013 and out_perr=0; done after 12 cycles of busy; err_count=0.
- Backpressure: same burst with out_ready low for 5 cycles on word 2 → out_valid, out_data=0x02 and out_addr held stable; no extra mem_read pulses; order is preserved.
- Parity fault: force-store 9'h0_07 at 0x0020 (three ones plus a 0 parity bit, total odd, so good) and 9'h1_07 at 0x0021 (four ones, even, so bad); length=2 → out_perr 0 then 1; err_count=1. With MEM_BURST_HALT_ON_PERR_EN, a 3-word burst starting 0x0021 stops after 1 word.
- Wrap and zero length: start_addr=0xFFFF, length=2 → mem_addr 0xFFFF then 0x0000. Separately, length=0 → done one cycle after start, mem_read never asserted.
- Reset mid-burst: drop rst_n during PRESENT of word 1 of 4 → all outputs 0 at the next edge, no done pulse. A start after reset release runs a clean burst.
- Start while busy: pulse start with a different start_addr mid-burst → ignored; the original address sequence completes.
